// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
//
// Iterative AES inverse cipher for AES-128/192/256, selected at run time.
// One inverse round per clock through a single shared round datapath.
//
// Loading a key expands the full forward key schedule into an on-chip word
// store, one 32-bit word per cycle. The schedule is then reused for any number
// of ciphertext blocks until the next key load.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   key_in     in   256     cipher key, MSB-aligned (128-bit key in [255:128])
//   key_mode   in   2       00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_valid  in   1       key_in/key_mode valid
//   key_ready  out  1       key accepted on key_valid & key_ready
//   in_data    in   128     ciphertext block
//   in_valid   in   1       in_data valid
//   in_ready   out  1       block accepted on in_valid & in_ready
//   out_data   out  128     plaintext block (zero when out_valid is low)
//   out_valid  out  1       out_data valid, held until out_ready
//   out_ready  in   1       sink accepts out_data
//   sched_ok   out  1       a complete key schedule is stored
//   key_err    out  1       last key load used key_mode=11
//   busy       out  1       FSM is not idle
// -----------------------------------------------------------------------------
module aes_decrypt_iter #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*MAX_NK-1:0]  key_in,
  input  logic [1:0]            key_mode,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [127:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [127:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sched_ok,
  output logic                  key_err,
  output logic                  busy
);

  localparam int KEY_W  = 32 * MAX_NK;
  localparam int NWORDS = 4 * (MAX_NK + 7);
  localparam int IDX_W  = $clog2(NWORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEXP  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The S-boxes are derived arithmetically (multiplicative
  // inverse plus affine map) instead of being stored as tables.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
             ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the block lives at [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_fsm;
  logic [1:0]       w_nxt;
  logic             r_key_rdy;
  logic             r_sched_ok;
  logic             r_key_err;
  logic [3:0]       r_nk;
  logic [3:0]       r_nr;
  logic [3:0]       r_round;
  logic [3:0]       r_kmod;      // i mod Nk for the word being expanded
  logic [7:0]       r_rcon;      // Rcon[i/Nk] for the next i%Nk==0 word
  logic [IDX_W-1:0] r_word;      // index of the word being expanded
  logic [31:0]      r_sched [NWORDS];
  logic [127:0]     r_blk;       // cipher state register

  logic             w_key_acc;
  logic             w_mode_ok;
  logic             w_in_ready;
  logic             w_blk_acc;
  logic [3:0]       w_nk_in;
  logic [3:0]       w_nr_in;
  logic [31:0]      w_prev;
  logic [31:0]      w_back;
  logic [31:0]      w_temp;
  logic [31:0]      w_new_word;
  logic             w_kexp_last;
  logic [3:0]       w_ridx;
  logic [IDX_W-1:0] w_rk_base;
  logic [127:0]     w_rk;
  logic [127:0]     w_isb;
  logic [127:0]     w_ark;
  logic [127:0]     w_imc;

  // ---------------------------------------------------------------------------
  // Handshakes and key-mode decode
  // ---------------------------------------------------------------------------
  // key_ready is registered so it reads 0 while reset is asserted and in the
  // first cycle after release, then follows "FSM is idle".
  assign key_ready  = r_key_rdy;
  assign w_key_acc  = key_valid & r_key_rdy;
  assign w_mode_ok  = (key_mode != 2'b11);
  // A pending key always wins over a block in the same cycle.
  assign w_in_ready = (r_fsm == S_IDLE) & r_sched_ok & ~key_valid;
  assign in_ready   = w_in_ready;
  assign w_blk_acc  = in_valid & w_in_ready;

  assign sched_ok   = r_sched_ok;
  assign key_err    = r_key_err;
  assign busy       = (r_fsm != S_IDLE);
  assign out_valid  = (r_fsm == S_DONE);
  assign out_data   = (r_fsm == S_DONE) ? r_blk : '0;

  always_comb begin
    w_nk_in = 4'd4;
    w_nr_in = 4'd10;
    case (key_mode)
      2'b01:   begin w_nk_in = 4'd6; w_nr_in = 4'd12; end
      2'b10:   begin w_nk_in = 4'd8; w_nr_in = 4'd14; end
      default: begin w_nk_in = 4'd4; w_nr_in = 4'd10; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key expansion: w[i] = w[i-Nk] ^ temp
  // ---------------------------------------------------------------------------
  assign w_prev = r_sched[r_word - IDX_W'(1)];
  assign w_back = r_sched[r_word - IDX_W'(r_nk)];

  always_comb begin
    w_temp = w_prev;
    if (r_kmod == 4'd0) begin
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
    end else if ((r_nk == 4'd8) && (r_kmod == 4'd4)) begin
      w_temp = sub_word(w_prev);
    end
  end

  assign w_new_word  = w_back ^ w_temp;
  assign w_kexp_last = (r_word == IDX_W'({r_nr, 2'b11}));  // 4*Nr+3

  // ---------------------------------------------------------------------------
  // Inverse round datapath. In IDLE the key port selects rk[Nr] for the
  // initial AddRoundKey; in ROUND it selects rk[r].
  // ---------------------------------------------------------------------------
  assign w_ridx    = (r_fsm == S_IDLE) ? r_nr : r_round;
  assign w_rk_base = IDX_W'({w_ridx, 2'b00});
  assign w_rk      = {r_sched[w_rk_base],
                      r_sched[w_rk_base + IDX_W'(1)],
                      r_sched[w_rk_base + IDX_W'(2)],
                      r_sched[w_rk_base + IDX_W'(3)]};

  assign w_isb = inv_sub_bytes(inv_shift_rows(r_blk));
  assign w_ark = w_isb ^ w_rk;
  assign w_imc = inv_mix_columns(w_ark);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (w_key_acc) begin
          if (w_mode_ok) w_nxt = S_KEXP;
        end else if (w_blk_acc) begin
          w_nxt = S_ROUND;
        end
      end
      S_KEXP:  if (w_kexp_last) w_nxt = S_IDLE;
      S_ROUND: if (r_round == 4'd0) w_nxt = S_DONE;
      S_DONE:  if (out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= S_IDLE;
      r_key_rdy  <= 1'b0;
      r_sched_ok <= 1'b0;
      r_key_err  <= 1'b0;
      r_nk       <= 4'd0;
      r_nr       <= 4'd0;
      r_round    <= 4'd0;
      r_kmod     <= 4'd0;
      r_rcon     <= 8'h00;
      r_word     <= '0;
    end else begin
      r_fsm     <= w_nxt;
      r_key_rdy <= (w_nxt == S_IDLE);
      case (r_fsm)
        S_IDLE: begin
          if (w_key_acc) begin
            r_sched_ok <= 1'b0;
            if (w_mode_ok) begin
              r_key_err <= 1'b0;
              r_nk      <= w_nk_in;
              r_nr      <= w_nr_in;
              r_word    <= IDX_W'(w_nk_in);
              r_kmod    <= 4'd0;
              r_rcon    <= 8'h01;
            end else begin
              r_key_err <= 1'b1;
            end
          end else if (w_blk_acc) begin
            r_round <= r_nr - 4'd1;
          end
        end
        S_KEXP: begin
          r_word <= r_word + IDX_W'(1);
          r_kmod <= (r_kmod == r_nk - 4'd1) ? 4'd0 : r_kmod + 4'd1;
          if (r_kmod == 4'd0) r_rcon <= xtime(r_rcon);
          if (w_kexp_last) r_sched_ok <= 1'b1;
        end
        S_ROUND: begin
          if (r_round != 4'd0) r_round <= r_round - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Schedule store and cipher state (data only, not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((r_fsm == S_IDLE) && w_key_acc && w_mode_ok) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(w_nk_in)) r_sched[IDX_W'(j)] <= key_in[KEY_W-1-32*j -: 32];
      end
    end else if (r_fsm == S_KEXP) begin
      r_sched[r_word] <= w_new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_blk_acc && !w_key_acc) begin
      r_blk <= in_data ^ w_rk;
    end else if (r_fsm == S_ROUND) begin
      r_blk <= (r_round == 4'd0) ? w_ark : w_imc;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
//
// Directed bench for aes_decrypt_iter using the FIPS-197 example vectors for
// AES-128/192/256, plus back-pressure, key/block priority, illegal key mode
// and mid-decrypt asynchronous reset.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic [1:0]   key_mode;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sched_ok;
  logic         key_err;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_mode  (key_mode),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sched_ok  (sched_ok),
    .key_err   (key_err),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a key for one accepted cycle and time the expansion.
  task automatic load_key(input logic [255:0] k, input logic [1:0] m,
                          input int exp_cyc, input string tag);
    int cnt;
    chk({tag, "_key_ready"}, 128'(key_ready), 128'd1);
    key_in    = k;
    key_mode  = m;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk({tag, "_kexp_busy"}, 128'(busy), 128'd1);
    chk({tag, "_kexp_sched_ok"}, 128'(sched_ok), 128'd0);
    chk({tag, "_kexp_key_ready"}, 128'(key_ready), 128'd0);
    cnt = 0;
    while (!sched_ok && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({tag, "_kexp_cycles"}, 128'(cnt), 128'(exp_cyc));
    chk({tag, "_sched_ok"}, 128'(sched_ok), 128'd1);
    chk({tag, "_key_err"}, 128'(key_err), 128'd0);
    chk({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic send_block(input logic [127:0] ct, input string tag);
    int i;
    i = 0;
    while (!in_ready && i < 100) begin
      tick();
      i++;
    end
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    in_data  = ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_round_busy"}, 128'(busy), 128'd1);
    chk({tag, "_early_valid"}, 128'(out_valid), 128'd0);
  endtask

  // Latency counts clock edges from and including the accept edge.
  task automatic wait_out(input int exp_lat, input logic [127:0] pt, input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_out_data"}, out_data, pt);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 128'(out_valid), 128'd0);
    chk({tag, "_out_data_zero"}, out_data, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    key_mode  = 2'b00;
    key_valid = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_key_ready", 128'(key_ready), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data",  out_data,        128'd0);
    chk("rst_sched_ok",  128'(sched_ok),  128'd0);
    chk("rst_key_err",   128'(key_err),   128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_key_ready", 128'(key_ready), 128'd1);
    chk("idle_no_sched_in_ready", 128'(in_ready), 128'd0);

    // T1 AES-128
    load_key(K128, 2'b00, 40, "t1");
    send_block(CT128, "t1");
    wait_out(11, PT, "t1");
    release_out("t1");

    // T4 back-pressure, then two more blocks on the same schedule
    send_block(CT128, "t4a");
    wait_out(11, PT, "t4a");
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_hold_data", out_data, PT);
      chk("t4_hold_in_ready", 128'(in_ready), 128'd0);
    end
    chk("t4_hold_valid", 128'(out_valid), 128'd1);
    release_out("t4a");
    send_block(CT128, "t4b");
    wait_out(11, PT, "t4b");
    release_out("t4b");
    send_block(CT128, "t4c");
    wait_out(11, PT, "t4c");
    release_out("t4c");

    // T2 AES-192
    load_key(K192, 2'b01, 46, "t2");
    send_block(CT192, "t2");
    wait_out(13, PT, "t2");
    release_out("t2");

    // T3 AES-256
    load_key(K256, 2'b10, 52, "t3");
    send_block(CT256, "t3");
    wait_out(15, PT, "t3");
    release_out("t3");

    // T5 key wins over a simultaneous block
    key_in    = K128;
    key_mode  = 2'b00;
    key_valid = 1'b1;
    in_data   = CT256;
    in_valid  = 1'b1;
    #1;
    chk("t5_prio_in_ready", 128'(in_ready), 128'd0);
    tick();
    key_valid = 1'b0;
    in_valid  = 1'b0;
    chk("t5_prio_kexp", 128'(busy), 128'd1);
    chk("t5_prio_sched_clr", 128'(sched_ok), 128'd0);
    for (int c = 0; c < 45 && !sched_ok; c++) tick();
    chk("t5_prio_sched_ok", 128'(sched_ok), 128'd1);
    chk("t5_prio_no_block", 128'(busy), 128'd0);
    chk("t5_prio_no_out", 128'(out_valid), 128'd0);
    send_block(CT128, "t5p");
    wait_out(11, PT, "t5p");
    release_out("t5p");

    // T5 illegal key mode
    key_in    = K256;
    key_mode  = 2'b11;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_mode  = 2'b00;
    in_data   = CT128;
    in_valid  = 1'b1;
    #1;
    chk("t5_ill_key_err", 128'(key_err), 128'd1);
    chk("t5_ill_sched_ok", 128'(sched_ok), 128'd0);
    chk("t5_ill_busy", 128'(busy), 128'd0);
    chk("t5_ill_in_ready", 128'(in_ready), 128'd0);
    chk("t5_ill_key_ready", 128'(key_ready), 128'd1);
    tick();
    tick();
    tick();
    chk("t5_ill_no_accept", 128'(busy), 128'd0);
    chk("t5_ill_in_ready_hold", 128'(in_ready), 128'd0);
    in_valid = 1'b0;

    // T6 asynchronous reset in the middle of a decryption
    load_key(K128, 2'b00, 40, "t6a");
    send_block(CT128, "t6a");
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",      128'(busy),      128'd0);
    chk("t6_rst_sched_ok",  128'(sched_ok),  128'd0);
    chk("t6_rst_out_valid", 128'(out_valid), 128'd0);
    chk("t6_rst_out_data",  out_data,        128'd0);
    chk("t6_rst_key_ready", 128'(key_ready), 128'd0);
    chk("t6_rst_in_ready",  128'(in_ready),  128'd0);
    chk("t6_rst_key_err",   128'(key_err),   128'd0);
    #1;
    rst_n = 1'b1;
    tick();
    load_key(K128, 2'b00, 40, "t6b");
    send_block(CT128, "t6b");
    wait_out(11, PT, "t6b");
    release_out("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
